datapath: RTL and testbench
===========================

DATAPATH -- requirements
Module: datapath

Interface
REQ-001 SHALL provide ports in this positional order: Clock, clear, Mdatain, Read, IncPC, Rin, Rout, PCin, Zin, MDRin, MARin, Yin, HIin, LOin, PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout, opcode.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 Clock  in  1  sole clock; all registers update on its rising edge.
REQ-004 clear  in  1  asynchronous active-low reset.
REQ-005 Mdatain  in  32  memory read data.
REQ-006 Read  in  1  MDR source select: 1 = Mdatain, 0 = bus.
REQ-007 IncPC  in  1  ALU override: result = bus + 1.
REQ-008 Rin  in  16  one-hot write enables; bit k selects Rk.
REQ-009 Rout  in  16  one-hot bus-drive selects; bit k selects Rk.
REQ-010 PCin, Zin, MDRin, MARin, Yin, HIin, LOin  in  1 each  register load enables.
REQ-011 PCout, Zhighout, Zlowout, HIout, LOout, MDRout  in  1 each  bus-drive selects.
REQ-012 Cout  in  1  bus-drive select for the constant source.
REQ-013 opcode  in  5  ALU operation code.

Function
REQ-014 Internal state SHALL be: R0-R15, PC, MAR, MDR, Y, HI, LO (32 bits each) and Z (64 bits, Zhigh = [63:32], Zlow = [31:0]).
REQ-015 The bus SHALL be a 32-bit multiplexer driven by the single asserted out-select.
REQ-016 Bus select priority SHALL be R0..R15 (lowest index first), then HI, LO, Zhigh, Zlow, PC, MDR, Cout.
REQ-017 The bus SHALL read 0 when no out-select is asserted.
REQ-018 The Cout source SHALL be 32'h00000000.
REQ-019 Rk, PC, MAR, Y, HI and LO SHALL load the bus on a rising edge when their enable is high; otherwise they hold.
REQ-020 MDR SHALL load Mdatain when MDRin=1 and Read=1, and the bus when MDRin=1 and Read=0.
REQ-021 The ALU SHALL be combinational, with A = Y, B = bus, 64-bit result C; Z SHALL load C when Zin=1.
REQ-022 IncPC=1 SHALL force C = {32'b0, B+1}, overriding opcode.
REQ-023 Opcodes: 00011 add; 00100 sub; 00101 and; 00110 or; 00111 shr (logical A>>B[4:0]); 01000 shra (arithmetic); 01001 shl; 01010 ror by B[4:0]; 01011 rol by B[4:0]; 01110 mul (signed A*B, full 64-bit product); 01111 div (Zlow = signed A/B quotient, Zhigh = remainder); 10000 neg (-B); 10001 not (~B); any other code gives C = {32'b0, B}.
REQ-024 For all ops except mul and div, C[63:32] SHALL be 0.
REQ-025 Add and sub SHALL wrap modulo 2^32.
REQ-026 Shift and rotate amounts of 0 SHALL pass A unchanged; amounts use B[4:0] only.
REQ-027 Division by zero SHALL give Zlow = 32'hFFFFFFFF and Zhigh = A.
REQ-028 On simultaneous out-select and in-enable of the same register, the register SHALL reload its own value.
REQ-029 Write latency SHALL be one edge: a value driven onto the bus is visible in the destination register after the next rising edge.

Reset
REQ-030 While clear=0, all registers (R0-R15, PC, MAR, MDR, Y, HI, LO, Z) SHALL clear to 0 immediately, independent of Clock.
REQ-031 Loads SHALL resume on the first rising edge after clear returns high; asserting clear mid-sequence SHALL discard all state.

Structure
REQ-032 Opcode constants and the bus-select encoding SHALL live in a shared package (datapath_pkg).
REQ-033 The ALU SHALL be one sub-module named alu; the register file, bus mux and special registers SHALL stay in datapath.

Verification
REQ-034 Load 32'h12 via MDR (Read, MDRin, then MDRout + Rin[3]) -> R3 = 32'h00000012; likewise R5 = 32'h14 and R1 = 32'h18.
REQ-035 With R3 = 0x12 and R5 = 0x14, apply R3out+Yin, then R5out + opcode 00111 + Zin, then Zlowout + Rin[1] -> R1 = 32'h00000000.
REQ-036 With PC = 0, apply PCout + MARin + IncPC + Zin, then Zlowout + PCin -> MAR = 0, PC = 1.
REQ-037 With Y = 32'hFFFFFFFF and bus = 1, opcode 00011 -> Zlow = 0, Zhigh = 0; opcode 01110 -> Z = 64'hFFFFFFFFFFFFFFFF.
REQ-038 Apply Y = 7, bus = 2, opcode 01111, then HIin from Zhigh and LOin from Zlow -> LO = 3, HI = 1.
REQ-039 Load R3, then pulse clear low between clock edges -> all registers read 0 immediately.

Source files
------------

// File: rtl/datapath_pkg.sv
// Shared opcode constants and bus-source encoding for the datapath slice.
package datapath_pkg;

   localparam int NUM_REGS = 16;
   localparam int NUM_SRC  = 23;

   typedef enum logic [4:0] {
      OP_ADD  = 5'b00011,
      OP_SUB  = 5'b00100,
      OP_AND  = 5'b00101,
      OP_OR   = 5'b00110,
      OP_SHR  = 5'b00111,
      OP_SHRA = 5'b01000,
      OP_SHL  = 5'b01001,
      OP_ROR  = 5'b01010,
      OP_ROL  = 5'b01011,
      OP_MUL  = 5'b01110,
      OP_DIV  = 5'b01111,
      OP_NEG  = 5'b10000,
      OP_NOT  = 5'b10001
   } opcode_e;

   // Codes 0..15 select R0..R15 directly; the rest follow in priority order.
   typedef logic [4:0] bus_sel_t;
   localparam bus_sel_t BUS_HI    = 5'd16;
   localparam bus_sel_t BUS_LO    = 5'd17;
   localparam bus_sel_t BUS_ZHI   = 5'd18;
   localparam bus_sel_t BUS_ZLO   = 5'd19;
   localparam bus_sel_t BUS_PC    = 5'd20;
   localparam bus_sel_t BUS_MDR   = 5'd21;
   localparam bus_sel_t BUS_CONST = 5'd22;
   localparam bus_sel_t BUS_NONE  = 5'd23;

   function automatic bus_sel_t bus_select(input logic [NUM_SRC-1:0] req);
      bus_sel_t sel;
      sel = BUS_NONE;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) sel = 5'(i);
      end
      return sel;
   endfunction

endpackage

// File: rtl/datapath_alu.sv
// Combinational ALU: A from Y, B from the bus, 64-bit result for the Z register.
module alu
   import datapath_pkg::*;
(
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [4:0]  opcode_i,
   input  logic        inc_pc_i,
   output logic [63:0] c_o
);

   logic [4:0]  sh;
   logic [63:0] prod;
   logic [63:0] rot_r;
   logic [63:0] rot_l;
   logic [31:0] quo;
   logic [31:0] rem;
   logic [31:0] shra;

   assign sh    = b_i[4:0];
   assign prod  = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
   assign rot_r = {a_i, a_i} >> sh;
   assign rot_l = {a_i, a_i} << sh;
   assign quo   = $signed(a_i) / $signed(b_i);
   assign rem   = $signed(a_i) % $signed(b_i);
   assign shra  = $signed(a_i) >>> sh;

   always_comb begin
      c_o = {32'b0, b_i};
      if (inc_pc_i) begin
         c_o = {32'b0, b_i + 32'd1};
      end else begin
         case (opcode_i)
            OP_ADD:  c_o = {32'b0, a_i + b_i};
            OP_SUB:  c_o = {32'b0, a_i - b_i};
            OP_AND:  c_o = {32'b0, a_i & b_i};
            OP_OR:   c_o = {32'b0, a_i | b_i};
            OP_SHR:  c_o = {32'b0, a_i >> sh};
            OP_SHRA: c_o = {32'b0, shra};
            OP_SHL:  c_o = {32'b0, a_i << sh};
            OP_ROR:  c_o = {32'b0, rot_r[31:0]};
            OP_ROL:  c_o = {32'b0, rot_l[63:32]};
            OP_MUL:  c_o = prod;
            // Divide by zero yields an all-ones quotient and keeps A as remainder.
            OP_DIV:  c_o = (b_i == 32'd0) ? {a_i, 32'hFFFF_FFFF} : {rem, quo};
            OP_NEG:  c_o = {32'b0, -b_i};
            OP_NOT:  c_o = {32'b0, ~b_i};
            default: c_o = {32'b0, b_i};
         endcase
      end
   end

endmodule

// File: rtl/datapath.sv
// Single-bus datapath: R0-R15, PC, MAR, MDR, Y, HI, LO and 64-bit Z around one ALU.
module datapath
   import datapath_pkg::*;
(
   input  logic        Clock,
   input  logic        clear,
   input  logic [31:0] Mdatain,
   input  logic        Read,
   input  logic        IncPC,
   input  logic [15:0] Rin,
   input  logic [15:0] Rout,
   input  logic        PCin,
   input  logic        Zin,
   input  logic        MDRin,
   input  logic        MARin,
   input  logic        Yin,
   input  logic        HIin,
   input  logic        LOin,
   input  logic        PCout,
   input  logic        Zhighout,
   input  logic        Zlowout,
   input  logic        HIout,
   input  logic        LOout,
   input  logic        MDRout,
   input  logic        Cout,
   input  logic [4:0]  opcode
);

   logic [31:0] r_q [NUM_REGS];
   logic [31:0] r_d [NUM_REGS];
   logic [31:0] pc_q, pc_d, mar_q, mar_d, mdr_q, mdr_d;
   logic [31:0] y_q, y_d, hi_q, hi_d, lo_q, lo_d;
   logic [63:0] z_q, z_d;
   logic [63:0] alu_c;
   logic [31:0] bus;
   bus_sel_t    bus_sel;
   logic        unused_mar;

   assign bus_sel = bus_select({Cout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout, Rout});

   always_comb begin
      bus = 32'b0;
      if (bus_sel < BUS_HI) begin
         bus = r_q[bus_sel[3:0]];
      end else begin
         case (bus_sel)
            BUS_HI:    bus = hi_q;
            BUS_LO:    bus = lo_q;
            BUS_ZHI:   bus = z_q[63:32];
            BUS_ZLO:   bus = z_q[31:0];
            BUS_PC:    bus = pc_q;
            BUS_MDR:   bus = mdr_q;
            BUS_CONST: bus = 32'h0000_0000;
            default:   bus = 32'b0;
         endcase
      end
   end

   alu u_alu (
      .a_i      (y_q),
      .b_i      (bus),
      .opcode_i (opcode),
      .inc_pc_i (IncPC),
      .c_o      (alu_c)
   );

   always_comb begin
      for (int k = 0; k < NUM_REGS; k++) begin
         r_d[k] = Rin[k] ? bus : r_q[k];
      end
      pc_d  = PCin  ? bus : pc_q;
      mar_d = MARin ? bus : mar_q;
      y_d   = Yin   ? bus : y_q;
      hi_d  = HIin  ? bus : hi_q;
      lo_d  = LOin  ? bus : lo_q;
      mdr_d = MDRin ? (Read ? Mdatain : bus) : mdr_q;
      z_d   = Zin   ? alu_c : z_q;
   end

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         for (int k = 0; k < NUM_REGS; k++) r_q[k] <= 32'b0;
         pc_q  <= 32'b0;
         mar_q <= 32'b0;
         mdr_q <= 32'b0;
         y_q   <= 32'b0;
         hi_q  <= 32'b0;
         lo_q  <= 32'b0;
         z_q   <= 64'b0;
      end else begin
         for (int k = 0; k < NUM_REGS; k++) r_q[k] <= r_d[k];
         pc_q  <= pc_d;
         mar_q <= mar_d;
         mdr_q <= mdr_d;
         y_q   <= y_d;
         hi_q  <= hi_d;
         lo_q  <= lo_d;
         z_q   <= z_d;
      end
   end

   // MAR feeds an external memory address that is outside this slice.
   assign unused_mar = ^mar_q;

endmodule

// File: tb/tb_datapath.sv
// Directed bench for datapath: register transfers, ALU ops, bus priority and async clear.
module tb_datapath;

   logic        Clock = 1'b0;
   logic        clear = 1'b1;
   logic [31:0] Mdatain;
   logic        Read, IncPC;
   logic [15:0] Rin, Rout;
   logic        PCin, Zin, MDRin, MARin, Yin, HIin, LOin;
   logic        PCout, Zhighout, Zlowout, HIout, LOout, MDRout, Cout;
   logic [4:0]  opcode;

   int errors = 0;
   int checks = 0;

   datapath dut (
      .Clock    (Clock),
      .clear    (clear),
      .Mdatain  (Mdatain),
      .Read     (Read),
      .IncPC    (IncPC),
      .Rin      (Rin),
      .Rout     (Rout),
      .PCin     (PCin),
      .Zin      (Zin),
      .MDRin    (MDRin),
      .MARin    (MARin),
      .Yin      (Yin),
      .HIin     (HIin),
      .LOin     (LOin),
      .PCout    (PCout),
      .Zhighout (Zhighout),
      .Zlowout  (Zlowout),
      .HIout    (HIout),
      .LOout    (LOout),
      .MDRout   (MDRout),
      .Cout     (Cout),
      .opcode   (opcode)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      Mdatain = 32'b0; Read = 1'b0; IncPC = 1'b0; Rin = 16'b0; Rout = 16'b0;
      PCin = 1'b0; Zin = 1'b0; MDRin = 1'b0; MARin = 1'b0; Yin = 1'b0;
      HIin = 1'b0; LOin = 1'b0; PCout = 1'b0; Zhighout = 1'b0; Zlowout = 1'b0;
      HIout = 1'b0; LOout = 1'b0; MDRout = 1'b0; Cout = 1'b0; opcode = 5'b0;
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
      idle();
   endtask

   task automatic load_mdr(input logic [31:0] v);
      Mdatain = v; Read = 1'b1; MDRin = 1'b1;
      tick();
   endtask

   task automatic load_r(input int k, input logic [31:0] v);
      load_mdr(v);
      MDRout = 1'b1; Rin = 16'(1) << k;
      tick();
   endtask

   task automatic run_alu(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op);
      load_mdr(a);
      MDRout = 1'b1; Yin = 1'b1;
      tick();
      load_mdr(b);
      MDRout = 1'b1; opcode = op; Zin = 1'b1;
      tick();
   endtask

   initial begin
      idle();
      #3 clear = 1'b0;
      #1;
      check("rst_r3", 64'(dut.r_q[3]), 64'h0);
      check("rst_pc", 64'(dut.pc_q), 64'h0);
      check("rst_z",  dut.z_q, 64'h0);
      @(posedge Clock); #1;
      clear = 1'b1;

      load_r(3, 32'h12);
      load_r(5, 32'h14);
      load_r(1, 32'h18);
      check("ld_r3", 64'(dut.r_q[3]), 64'h12);
      check("ld_r5", 64'(dut.r_q[5]), 64'h14);
      check("ld_r1", 64'(dut.r_q[1]), 64'h18);

      // shr 0x12 by 20 -> 0
      Rout[3] = 1'b1; Yin = 1'b1; tick();
      Rout[5] = 1'b1; opcode = 5'b00111; Zin = 1'b1; tick();
      Zlowout = 1'b1; Rin[1] = 1'b1; tick();
      check("shr_r1", 64'(dut.r_q[1]), 64'h0);

      PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; tick();
      Zlowout = 1'b1; PCin = 1'b1; tick();
      check("inc_mar", 64'(dut.mar_q), 64'h0);
      check("inc_pc",  64'(dut.pc_q), 64'h1);

      run_alu(32'hFFFF_FFFF, 32'h1, 5'b00011);
      check("add_wrap", dut.z_q, 64'h0);
      run_alu(32'hFFFF_FFFF, 32'h1, 5'b01110);
      check("mul_m1", dut.z_q, 64'hFFFF_FFFF_FFFF_FFFF);

      run_alu(32'd7, 32'd2, 5'b01111);
      Zhighout = 1'b1; HIin = 1'b1; tick();
      Zlowout = 1'b1; LOin = 1'b1; tick();
      check("div_lo", 64'(dut.lo_q), 64'd3);
      check("div_hi", 64'(dut.hi_q), 64'd1);

      run_alu(32'd5, 32'd7, 5'b00100);          check("sub",     dut.z_q, 64'h0000_0000_FFFF_FFFE);
      run_alu(32'hF0F0_1234, 32'h0FF0_FF00, 5'b00101); check("and", dut.z_q, 64'h0000_0000_00F0_1200);
      run_alu(32'hF000_0001, 32'h0000_0F10, 5'b00110); check("or",  dut.z_q, 64'h0000_0000_F000_0F11);
      run_alu(32'h8000_0000, 32'd4, 5'b01000);  check("shra",    dut.z_q, 64'h0000_0000_F800_0000);
      run_alu(32'h0000_0001, 32'd31, 5'b01001); check("shl",     dut.z_q, 64'h0000_0000_8000_0000);
      run_alu(32'h0000_0001, 32'd1, 5'b01010);  check("ror",     dut.z_q, 64'h0000_0000_8000_0000);
      run_alu(32'h8000_0001, 32'd4, 5'b01011);  check("rol",     dut.z_q, 64'h0000_0000_0000_0018);
      run_alu(32'hABCD_0123, 32'd32, 5'b00111); check("shr_amt0", dut.z_q, 64'h0000_0000_ABCD_0123);
      run_alu(32'hABCD_0123, 32'h21, 5'b01011); check("rol_b40", dut.z_q, 64'h0000_0000_579A_0247);
      run_alu(32'hFFFF_FFFD, 32'd4, 5'b01110);  check("mul_neg", dut.z_q, 64'hFFFF_FFFF_FFFF_FFF4);
      run_alu(32'hFFFF_FFF9, 32'd2, 5'b01111);  check("div_neg", dut.z_q, 64'hFFFF_FFFF_FFFF_FFFD);
      run_alu(32'd9, 32'd0, 5'b01111);          check("div_zero", dut.z_q, 64'h0000_0009_FFFF_FFFF);
      run_alu(32'd1, 32'd5, 5'b10000);          check("neg",     dut.z_q, 64'h0000_0000_FFFF_FFFB);
      run_alu(32'd1, 32'h0000_00FF, 5'b10001);  check("not",     dut.z_q, 64'h0000_0000_FFFF_FF00);
      run_alu(32'd1, 32'h55, 5'b00000);         check("op_dflt", dut.z_q, 64'h0000_0000_0000_0055);

      load_mdr(32'd5);
      MDRout = 1'b1; opcode = 5'b00011; IncPC = 1'b1; Zin = 1'b1; tick();
      check("incpc_ovr", dut.z_q, 64'h6);

      Rout[3] = 1'b1; Rout[5] = 1'b1; Rin[7] = 1'b1; tick();
      check("prio_rr", 64'(dut.r_q[7]), 64'h12);
      Rout[5] = 1'b1; HIout = 1'b1; Rin[8] = 1'b1; tick();
      check("prio_rhi", 64'(dut.r_q[8]), 64'h14);
      load_r(2, 32'hDEAD_BEEF);
      Rin[2] = 1'b1; tick();
      check("bus_none", 64'(dut.r_q[2]), 64'h0);
      load_r(9, 32'h1234_5678);
      Cout = 1'b1; MDRout = 1'b1; Rin[9] = 1'b1; tick();
      check("bus_mdr_cout", 64'(dut.r_q[9]), 64'h1234_5678);
      Cout = 1'b1; Rin[9] = 1'b1; tick();
      check("cout_zero", 64'(dut.r_q[9]), 64'h0);
      Rout[5] = 1'b1; Rin[5] = 1'b1; tick();
      check("self_load", 64'(dut.r_q[5]), 64'h14);

      load_r(3, 32'h77);
      #2 clear = 1'b0;
      #1;
      check("clr_r3", 64'(dut.r_q[3]), 64'h0);
      check("clr_r5", 64'(dut.r_q[5]), 64'h0);
      check("clr_pc", 64'(dut.pc_q), 64'h0);
      check("clr_hi", 64'(dut.hi_q), 64'h0);
      check("clr_z",  dut.z_q, 64'h0);
      #1 clear = 1'b1;
      load_r(4, 32'hCAFE);
      check("post_clr", 64'(dut.r_q[4]), 64'hCAFE);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
